// File: rtl/msg_request_scheduler.sv
// -----------------------------------------------------------------------------
// msg_request_scheduler
//
// Queues message-creation requests from the session manager and hands them,
// one at a time and in arrival order, to the create-message engine. A request
// is only issued when the engine is not busy. The scheduler then waits for the
// engine's done pulse, with a watchdog that abandons the request if done never
// arrives.
//
// Ports
//   clk                 : clock, rising-edge
//   rst                 : synchronous active-high reset
//   initiate_msg_i      : request strobe (type 4'b0000 means "no request")
//   create_message_i    : message type code
//   targetCompId_i      : destination TargetCompID value
//   s_v_targetCompId_i  : TargetCompID size field
//   cm_busy_i           : create-message engine busy
//   cm_done_i           : create-message engine done (1-cycle pulse)
//   initiate_msg_o      : 1-cycle issue strobe to the engine
//   create_message_o    : issued message type (held until next issue)
//   targetCompId_o      : issued TargetCompID (held until next issue)
//   s_v_targetCompId_o  : issued size field (held until next issue)
//   pending_o           : queued, not yet issued requests
//   full_o              : request FIFO full
//   overflow_o          : 1-cycle pulse, a request was dropped
//   timeout_o           : 1-cycle pulse, watchdog expired
// -----------------------------------------------------------------------------

`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 32
`endif
`ifndef VALUE_SIZE
`define VALUE_SIZE 6
`endif
`ifndef LOGON
`define LOGON 4'd1
`endif
`ifndef LOGOUT
`define LOGOUT 4'd2
`endif
`ifndef HEARTBEAT
`define HEARTBEAT 4'd3
`endif
`ifndef resendReq
`define resendReq 4'd4
`endif

module msg_request_scheduler #(
  parameter int VALUE_WIDTH = `VALUE_DATA_WIDTH,
  parameter int SIZE        = `VALUE_SIZE,
  parameter int DEPTH_LOG2  = 3,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   initiate_msg_i,
  input  logic [3:0]             create_message_i,
  input  logic [VALUE_WIDTH-1:0] targetCompId_i,
  input  logic [SIZE-1:0]        s_v_targetCompId_i,
  input  logic                   cm_busy_i,
  input  logic                   cm_done_i,
  output logic                   initiate_msg_o,
  output logic [3:0]             create_message_o,
  output logic [VALUE_WIDTH-1:0] targetCompId_o,
  output logic [SIZE-1:0]        s_v_targetCompId_o,
  output logic [DEPTH_LOG2:0]    pending_o,
  output logic                   full_o,
  output logic                   overflow_o,
  output logic                   timeout_o
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = 4 + VALUE_WIDTH + SIZE;
  localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_WAIT_DONE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;

  logic [WD_W-1:0]       r_wdog;

  logic                   r_initiate;
  logic [3:0]             r_type;
  logic [VALUE_WIDTH-1:0] r_id;
  logic [SIZE-1:0]        r_size;
  logic                   r_overflow;
  logic                   r_timeout;

  logic               w_full;
  logic               w_empty;
  logic               w_req;
  logic               w_push;
  logic               w_drop;
  logic               w_pop;
  logic               w_expire;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_head;

  assign w_full  = (r_count == (DEPTH_LOG2+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  // A zero type code is a null request: neither queued nor counted as dropped.
  assign w_req   = initiate_msg_i && (create_message_i != 4'b0000);

  // A full FIFO can still take a request when the head leaves in the same cycle.
  assign w_push  = w_req && (!w_full || w_pop);
  assign w_drop  = w_req && w_full && !w_pop;

  assign w_wdata = {create_message_i, targetCompId_i, s_v_targetCompId_i};
  assign w_head  = r_mem[r_rd_ptr];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // done wins over an expiring watchdog in the same cycle
        if (cm_done_i || w_expire) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_pop    = 1'b0;
    w_expire = 1'b0;
    unique case (r_state)
      ST_IDLE:      w_pop    = !w_empty && !cm_busy_i;
      ST_WAIT_DONE: w_expire = !cm_done_i && (r_wdog == WD_W'(TIMEOUT - 1));
      default: begin
        w_pop    = 1'b0;
        w_expire = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  // Pointers wrap naturally at 2^DEPTH_LOG2; the occupancy counter
  // separates full from empty when they are equal.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog: restarts on every issue, counts while waiting for done
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || w_pop) begin
      r_wdog <= '0;
    end else if (r_state == ST_WAIT_DONE) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs; issued fields only change on the next issue
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_initiate <= 1'b0;
      r_type     <= '0;
      r_id       <= '0;
      r_size     <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_initiate <= w_pop;
      r_overflow <= w_drop;
      r_timeout  <= w_expire;
      if (w_pop) begin
        {r_type, r_id, r_size} <= w_head;
      end
    end
  end

  assign initiate_msg_o     = r_initiate;
  assign create_message_o   = r_type;
  assign targetCompId_o     = r_id;
  assign s_v_targetCompId_o = r_size;
  assign pending_o          = r_count;
  assign full_o             = w_full;
  assign overflow_o         = r_overflow;
  assign timeout_o          = r_timeout;

endmodule

// File: tb/tb_msg_request_scheduler.sv
// -----------------------------------------------------------------------------
// Directed testbench for msg_request_scheduler.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_msg_request_scheduler;

  localparam int VW  = 32;
  localparam int SW  = 6;
  localparam int DL2 = 3;
  localparam int TO  = 16;

  localparam logic [3:0] T_LOGON  = 4'd1;
  localparam logic [3:0] T_LOGOUT = 4'd2;
  localparam logic [3:0] T_HB     = 4'd3;
  localparam logic [3:0] T_RESEND = 4'd4;

  logic          clk;
  logic          rst;
  logic          initiate_msg_i;
  logic [3:0]    create_message_i;
  logic [VW-1:0] targetCompId_i;
  logic [SW-1:0] s_v_targetCompId_i;
  logic          cm_busy_i;
  logic          cm_done_i;
  logic          initiate_msg_o;
  logic [3:0]    create_message_o;
  logic [VW-1:0] targetCompId_o;
  logic [SW-1:0] s_v_targetCompId_o;
  logic [DL2:0]  pending_o;
  logic          full_o;
  logic          overflow_o;
  logic          timeout_o;

  int n_vec;
  int n_err;

  msg_request_scheduler #(
    .VALUE_WIDTH(VW),
    .SIZE(SW),
    .DEPTH_LOG2(DL2),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .initiate_msg_i(initiate_msg_i),
    .create_message_i(create_message_i),
    .targetCompId_i(targetCompId_i),
    .s_v_targetCompId_i(s_v_targetCompId_i),
    .cm_busy_i(cm_busy_i),
    .cm_done_i(cm_done_i),
    .initiate_msg_o(initiate_msg_o),
    .create_message_o(create_message_o),
    .targetCompId_o(targetCompId_o),
    .s_v_targetCompId_o(s_v_targetCompId_o),
    .pending_o(pending_o),
    .full_o(full_o),
    .overflow_o(overflow_o),
    .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] t, input logic [VW-1:0] id, input logic [SW-1:0] sz);
    initiate_msg_i     = 1'b1;
    create_message_i   = t;
    targetCompId_i     = id;
    s_v_targetCompId_i = sz;
  endtask

  task automatic no_req();
    initiate_msg_i     = 1'b0;
    create_message_i   = 4'd0;
    targetCompId_i     = '0;
    s_v_targetCompId_i = '0;
  endtask

  task automatic done_pulse();
    cm_done_i = 1'b1;
    tick();
    cm_done_i = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    req(T_LOGON, 32'hDEAD, 6'd3);   // must be discarded
    tick();
    tick();
    rst = 1'b0;
    no_req();
    n_vec++; if (pending_o !== 4'd0) begin n_err++; $display("FAIL reset_pending got=%0d exp=0", pending_o); end
    n_vec++; if ({initiate_msg_o, create_message_o, targetCompId_o, s_v_targetCompId_o, full_o, overflow_o, timeout_o} !== '0) begin
      n_err++; $display("FAIL reset_outputs got init=%0b type=%0h id=%0h sz=%0h full=%0b ovf=%0b to=%0b exp all 0",
                        initiate_msg_o, create_message_o, targetCompId_o, s_v_targetCompId_o, full_o, overflow_o, timeout_o);
    end
    tick(); tick();
    n_vec++; if (initiate_msg_o !== 1'b0 || pending_o !== 4'd0) begin n_err++; $display("FAIL reset_discard got init=%0b pend=%0d exp 0/0", initiate_msg_o, pending_o); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    req(T_LOGON, 32'h41, 6'd5);
    tick();                              // push
    no_req();
    n_vec++; if (initiate_msg_o !== 1'b0 || pending_o !== 4'd1) begin n_err++; $display("FAIL single_n1 got init=%0b pend=%0d exp 0/1", initiate_msg_o, pending_o); end
    req(4'd0, 32'h99, 6'd1);             // null request: ignored
    tick();                              // pop/issue
    no_req();
    $display("issue type=%0h id=%0h sz=%0d", create_message_o, targetCompId_o, s_v_targetCompId_o);
    n_vec++; if (initiate_msg_o !== 1'b1) begin n_err++; $display("FAIL single_issue got=%0b exp=1", initiate_msg_o); end
    n_vec++; if (create_message_o !== T_LOGON || targetCompId_o !== 32'h41 || s_v_targetCompId_o !== 6'd5) begin
      n_err++; $display("FAIL single_fields got type=%0h id=%0h sz=%0d exp 1/41/5", create_message_o, targetCompId_o, s_v_targetCompId_o);
    end
    n_vec++; if (pending_o !== 4'd0 || overflow_o !== 1'b0) begin n_err++; $display("FAIL single_pending got pend=%0d ovf=%0b exp 0/0", pending_o, overflow_o); end
    tick();
    n_vec++; if (initiate_msg_o !== 1'b0) begin n_err++; $display("FAIL single_pulse_width got=%0b exp=0", initiate_msg_o); end
    n_vec++; if (targetCompId_o !== 32'h41 || create_message_o !== T_LOGON) begin n_err++; $display("FAIL single_hold got id=%0h type=%0h exp 41/1", targetCompId_o, create_message_o); end
    done_pulse();
    tick();
    n_vec++; if (initiate_msg_o !== 1'b0 || timeout_o !== 1'b0) begin n_err++; $display("FAIL single_idle got init=%0b to=%0b exp 0/0", initiate_msg_o, timeout_o); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [3:0] types [3];
    types[0] = T_LOGOUT; types[1] = T_HB; types[2] = T_RESEND;
    cm_busy_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req(types[k], 32'h10 + k, 6'(k + 1));
      tick();
    end
    no_req();
    tick();
    n_vec++; if (pending_o !== 4'd3 || initiate_msg_o !== 1'b0) begin n_err++; $display("FAIL bp_hold got pend=%0d init=%0b exp 3/0", pending_o, initiate_msg_o); end
    cm_done_i = 1'b1;                    // done while idle: ignored
    tick();
    cm_done_i = 1'b0;
    cm_busy_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("issue type=%0h id=%0h sz=%0d", create_message_o, targetCompId_o, s_v_targetCompId_o);
      n_vec++; if (initiate_msg_o !== 1'b1 || targetCompId_o !== 32'h10 + k || create_message_o !== types[k]) begin
        n_err++; $display("FAIL bp_order%0d got init=%0b id=%0h type=%0h exp 1/%0h/%0h", k, initiate_msg_o, targetCompId_o, create_message_o, 32'h10 + k, types[k]);
      end
      n_vec++; if (pending_o !== 4'(2 - k)) begin n_err++; $display("FAIL bp_pending%0d got=%0d exp=%0d", k, pending_o, 2 - k); end
      tick(); tick();
      n_vec++; if (initiate_msg_o !== 1'b0) begin n_err++; $display("FAIL bp_wait%0d got=%0b exp=0", k, initiate_msg_o); end
      done_pulse();
    end
    tick();
    n_vec++; if (initiate_msg_o !== 1'b0 || pending_o !== 4'd0) begin n_err++; $display("FAIL bp_drained got init=%0b pend=%0d exp 0/0", initiate_msg_o, pending_o); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overflow();
    cm_busy_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req(T_HB, 32'h20 + i, 6'd2);
      tick();
      if (i == 6) begin
        n_vec++; if (full_o !== 1'b0) begin n_err++; $display("FAIL ovf_not_full got=%0b exp=0", full_o); end
      end
    end
    n_vec++; if (full_o !== 1'b1 || pending_o !== 4'd8 || overflow_o !== 1'b0) begin
      n_err++; $display("FAIL ovf_full got full=%0b pend=%0d ovf=%0b exp 1/8/0", full_o, pending_o, overflow_o);
    end
    req(T_HB, 32'h2F, 6'd2);             // 9th: dropped
    tick();
    no_req();
    n_vec++; if (overflow_o !== 1'b1 || pending_o !== 4'd8) begin n_err++; $display("FAIL ovf_pulse got ovf=%0b pend=%0d exp 1/8", overflow_o, pending_o); end
    tick();
    n_vec++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_once got=%0b exp=0", overflow_o); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_full_pushpop();
    cm_busy_i = 1'b0;
    req(T_LOGON, 32'h30, 6'd7);
    tick();
    no_req();
    n_vec++; if (pending_o !== 4'd8 || overflow_o !== 1'b0 || full_o !== 1'b1) begin
      n_err++; $display("FAIL pp_count got pend=%0d ovf=%0b full=%0b exp 8/0/1", pending_o, overflow_o, full_o);
    end
    n_vec++; if (initiate_msg_o !== 1'b1 || targetCompId_o !== 32'h20) begin n_err++; $display("FAIL pp_issue got init=%0b id=%0h exp 1/20", initiate_msg_o, targetCompId_o); end
    for (int i = 1; i <= 8; i++) begin
      done_pulse();
      tick();
      n_vec++; if (initiate_msg_o !== 1'b1 || targetCompId_o !== ((i == 8) ? 32'h30 : 32'h20 + i)) begin
        n_err++; $display("FAIL pp_drain%0d got init=%0b id=%0h exp 1/%0h", i, initiate_msg_o, targetCompId_o, (i == 8) ? 32'h30 : 32'h20 + i);
      end
    end
    n_vec++; if (create_message_o !== T_LOGON || s_v_targetCompId_o !== 6'd7) begin n_err++; $display("FAIL pp_last got type=%0h sz=%0d exp 1/7", create_message_o, s_v_targetCompId_o); end
    done_pulse();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_watchdog();
    int early;
    cm_busy_i = 1'b0;
    req(T_HB, 32'h50, 6'd1);
    tick();
    req(T_HB, 32'h51, 6'd1);
    tick();                              // issue 0x50, push 0x51
    no_req();
    n_vec++; if (initiate_msg_o !== 1'b1 || targetCompId_o !== 32'h50) begin n_err++; $display("FAIL wd_issue got init=%0b id=%0h exp 1/50", initiate_msg_o, targetCompId_o); end
    early = 0;
    for (int k = 1; k < TO; k++) begin
      tick();
      if (timeout_o !== 1'b0 || initiate_msg_o !== 1'b0) early++;
    end
    n_vec++; if (early != 0) begin n_err++; $display("FAIL wd_early got=%0d early cycles exp=0", early); end
    tick();
    n_vec++; if (timeout_o !== 1'b1) begin n_err++; $display("FAIL wd_expire got=%0b exp=1", timeout_o); end
    tick();
    n_vec++; if (timeout_o !== 1'b0 || initiate_msg_o !== 1'b1 || targetCompId_o !== 32'h51) begin
      n_err++; $display("FAIL wd_next got to=%0b init=%0b id=%0h exp 0/1/51", timeout_o, initiate_msg_o, targetCompId_o);
    end
    for (int k = 1; k < TO; k++) tick();
    cm_done_i = 1'b1;                    // done exactly on the expiry cycle
    tick();
    cm_done_i = 1'b0;
    n_vec++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL wd_done_wins got=%0b exp=0", timeout_o); end
    tick();
    n_vec++; if (timeout_o !== 1'b0 || initiate_msg_o !== 1'b0) begin n_err++; $display("FAIL wd_after got to=%0b init=%0b exp 0/0", timeout_o, initiate_msg_o); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    cm_busy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req(T_LOGOUT, 32'h60 + i, 6'd4);
      tick();
    end
    no_req();
    n_vec++; if (pending_o !== 4'd4 || targetCompId_o !== 32'h60) begin n_err++; $display("FAIL rm_setup got pend=%0d id=%0h exp 4/60", pending_o, targetCompId_o); end
    rst = 1'b1;
    req(T_LOGON, 32'h70, 6'd1);          // discarded with reset
    tick();
    rst = 1'b0;
    no_req();
    n_vec++; if ({initiate_msg_o, create_message_o, targetCompId_o, s_v_targetCompId_o, full_o, overflow_o, timeout_o} !== '0 || pending_o !== 4'd0) begin
      n_err++; $display("FAIL rm_cleared got init=%0b type=%0h id=%0h pend=%0d exp all 0", initiate_msg_o, create_message_o, targetCompId_o, pending_o);
    end
    done_pulse();
    tick();
    n_vec++; if (initiate_msg_o !== 1'b0 || pending_o !== 4'd0 || targetCompId_o !== '0) begin
      n_err++; $display("FAIL rm_done_ignored got init=%0b pend=%0d id=%0h exp 0/0/0", initiate_msg_o, pending_o, targetCompId_o);
    end
    req(T_LOGON, 32'h71, 6'd2);
    tick();
    no_req();
    tick();
    n_vec++; if (initiate_msg_o !== 1'b1 || targetCompId_o !== 32'h71 || create_message_o !== T_LOGON) begin
      n_err++; $display("FAIL rm_new got init=%0b id=%0h type=%0h exp 1/71/1", initiate_msg_o, targetCompId_o, create_message_o);
    end
    done_pulse();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    cm_busy_i = 1'b0;
    cm_done_i = 1'b0;
    no_req();
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pushpop();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout got=no_finish exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/msg_request_scheduler.md
MSG_REQUEST_SCHEDULER -- requirements
Module: msg_request_scheduler

Interface
REQ-001 SHALL have parameter VALUE_WIDTH, default `VALUE_DATA_WIDTH, meaning the TargetCompID value width.
REQ-002 SHALL have parameter SIZE, default `VALUE_SIZE, meaning the TargetCompID size-field width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 3, meaning the request FIFO depth is 2^DEPTH_LOG2 (8).
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning the watchdog cycle limit while waiting for done.
REQ-005 clk  input  1  clock; all logic samples on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 initiate_msg_i  input  1  request strobe from session manager.
REQ-008 create_message_i  input  4  message type code (`logon, `logout, `heartbeat, `resendReq).
REQ-009 targetCompId_i  input  VALUE_WIDTH  destination TargetCompID.
REQ-010 s_v_targetCompId_i  input  SIZE  TargetCompID size field.
REQ-011 cm_busy_i  input  1  create-message engine busy.
REQ-012 cm_done_i  input  1  create-message engine finished current message (1-cycle pulse).
REQ-013 initiate_msg_o  output  1  issue strobe to create-message engine.
REQ-014 create_message_o  output  4  issued message type.
REQ-015 targetCompId_o  output  VALUE_WIDTH  issued TargetCompID.
REQ-016 s_v_targetCompId_o  output  SIZE  issued size field.
REQ-017 pending_o  output  DEPTH_LOG2+1  number of queued, unissued requests (0..2^DEPTH_LOG2).
REQ-018 full_o  output  1  FIFO full.
REQ-019 overflow_o  output  1  1-cycle pulse: request dropped.
REQ-020 timeout_o  output  1  1-cycle pulse: watchdog expired.

Function
REQ-021 SHALL push {create_message_i, targetCompId_i, s_v_targetCompId_i} into the FIFO on any cycle with initiate_msg_i=1 and create_message_i!=4'b0000.
REQ-022 SHALL ignore a request whose type is 4'b0000, with no push and no overflow.
REQ-023 SHALL drop a push when the FIFO is full and no pop occurs in the same cycle, pulsing overflow_o the next cycle.
REQ-024 SHALL accept a push when the FIFO is full and a pop occurs in the same cycle, leaving pending_o unchanged.
REQ-025 SHALL wrap read/write pointers modulo 2^DEPTH_LOG2, with full/empty distinguished by an extra pointer bit or occupancy counter.
REQ-026 FSM SHALL have states IDLE and WAIT_DONE, reset state IDLE.
REQ-027 IDLE: when the FIFO is non-empty and cm_busy_i=0, SHALL pop the head, register it onto the *_o fields, pulse initiate_msg_o for exactly one cycle, and go to WAIT_DONE.
REQ-028 IDLE: when cm_busy_i=1, SHALL hold without issuing.
REQ-029 WAIT_DONE: on cm_done_i=1, SHALL go to IDLE; the earliest next issue is the following cycle.
REQ-030 cm_done_i in IDLE SHALL be ignored.
REQ-031 SHALL hold create_message_o, targetCompId_o and s_v_targetCompId_o stable from issue until the next issue.
REQ-032 SHALL clear the watchdog on entry to WAIT_DONE and increment it each WAIT_DONE cycle.
REQ-033 When the watchdog reaches TIMEOUT-1 without cm_done_i, SHALL pulse timeout_o and return to IDLE; the request is not retried.
REQ-034 cm_done_i on the same cycle as watchdog expiry SHALL take precedence, with no timeout_o.
REQ-035 Latency: a request sampled at cycle N into an empty FIFO, with IDLE and cm_busy_i=0, SHALL produce initiate_msg_o at cycle N+2 (push N, pop/issue N+1, registered output N+2).
REQ-036 SHALL preserve strict FIFO order, with no priority reordering between message types.

Reset
REQ-037 rst=1 SHALL, at the next edge, zero all outputs, empty the FIFO, clear the watchdog and force IDLE, including mid-WAIT_DONE.
REQ-038 A request presented in the same cycle as rst=1 SHALL be discarded.

Verification
REQ-039 Single request: type `logon, id 0x41 into idle, not-busy -> initiate_msg_o=1 for 1 cycle at N+2 with create_message_o=`logon, targetCompId_o=0x41; pending_o returns to 0.
REQ-040 Backpressure: cm_busy_i=1, 3 requests pushed -> pending_o=3 and no issue; release busy and give cm_done_i per issue -> 3 issues in push order, each after the prior done.
REQ-041 Overflow: cm_busy_i=1, 9 pushes -> full_o=1 after the 8th; 9th drops, overflow_o pulses once, pending_o=8.
REQ-042 Full with simultaneous push/pop: FIFO full, busy drops while a push arrives -> push accepted, pending_o stays 8, overflow_o=0.
REQ-043 Watchdog: issue, then withhold cm_done_i -> timeout_o pulses after TIMEOUT cycles, FSM returns to IDLE, next queued request issues; done on the expiry cycle -> no timeout_o.
REQ-044 Reset mid-operation: in WAIT_DONE with 4 pending, assert rst 1 cycle -> all outputs 0, pending_o=0, subsequent cm_done_i ignored, new request issues normally.
